// File: rtl/card_shoe.sv
// ---------------------------------------------------------------------------
// card_shoe : 52-card no-repeat dealer with LFSR start index and linear probe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module card_shoe #(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         LOW_MARK  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw,
  input  logic       shuffle,
  output logic [3:0] card,
  output logic [1:0] suit,
  output logic       card_valid,
  output logic       busy,
  output logic [5:0] remaining,
  output logic       low_shoe,
  output logic       draw_err
);

  localparam logic [5:0] LOW_MARK_W = 6'(LOW_MARK);
  localparam logic [5:0] DECK_SIZE  = 6'd52;
  localparam logic [5:0] LAST_IDX   = 6'd51;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [51:0] used;
  logic [5:0]  idx;
  logic [7:0]  lfsr;
  logic [5:0]  start_idx;
  logic [3:0]  map_rank;
  logic [1:0]  map_suit;
  logic        hit;

  // Fold the 64-value LFSR slice into 0..51 without a divider.
  assign start_idx  = (lfsr[5:0] < DECK_SIZE) ? lfsr[5:0] : lfsr[5:0] - DECK_SIZE;
  assign hit        = ~used[idx];
  assign card_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign low_shoe   = (remaining < LOW_MARK_W);

  always_comb begin
    map_rank = 4'd0;
    map_suit = 2'd0;
    if (idx < 6'd13) begin
      map_suit = 2'd0;
      map_rank = 4'(idx + 6'd1);
    end else if (idx < 6'd26) begin
      map_suit = 2'd1;
      map_rank = 4'(idx - 6'd12);
    end else if (idx < 6'd39) begin
      map_suit = 2'd2;
      map_rank = 4'(idx - 6'd25);
    end else begin
      map_suit = 2'd3;
      map_rank = 4'(idx - 6'd38);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (draw && (remaining != 6'd0)) state_nx = SEARCH;
      SEARCH:  if (hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      used      <= '0;
      remaining <= DECK_SIZE;
      lfsr      <= LFSR_SEED;
      idx       <= 6'd0;
      card      <= 4'd0;
      suit      <= 2'd0;
      draw_err  <= 1'b0;
    end else begin
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      draw_err <= 1'b0;
      case (state)
        IDLE: begin
          // draw takes priority; a simultaneous shuffle is dropped
          if (draw) begin
            if (remaining != 6'd0) idx      <= start_idx;
            else                   draw_err <= 1'b1;
          end else if (shuffle) begin
            used      <= '0;
            remaining <= DECK_SIZE;
          end
        end
        SEARCH: begin
          if (hit) begin
            used[idx] <= 1'b1;
            remaining <= remaining - 6'd1;
            card      <= map_rank;
            suit      <= map_suit;
          end else begin
            idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_card_shoe.sv
// ---------------------------------------------------------------------------
// tb_card_shoe : directed self-checking bench for card_shoe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_card_shoe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       draw = 1'b0;
  logic       shuffle = 1'b0;
  logic [3:0] card;
  logic [1:0] suit;
  logic       card_valid;
  logic       busy;
  logic [5:0] remaining;
  logic       low_shoe;
  logic       draw_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] lfsr_m;

  card_shoe #(.LFSR_SEED(8'h01), .LOW_MARK(15)) dut (
    .clk(clk), .reset(reset), .draw(draw), .shuffle(shuffle),
    .card(card), .suit(suit), .card_valid(card_valid), .busy(busy),
    .remaining(remaining), .low_shoe(low_shoe), .draw_err(draw_err)
  );

  always #5 clk = ~clk;

  // Reference LFSR so the bench can pick the cycle giving a wanted start index.
  always @(posedge clk) begin
    if (reset) lfsr_m <= 8'h01;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  function automatic int start_of(input logic [7:0] l);
    int v;
    v = int'(l[5:0]);
    return (v < 52) ? v : v - 52;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one draw (optionally with shuffle), wait for card_valid, then move to IDLE.
  task automatic do_draw(input logic with_shuffle, output int lat, output int c,
                         output int s, output logic ok);
    draw    = 1'b1;
    shuffle = with_shuffle;
    step();
    draw    = 1'b0;
    shuffle = 1'b0;
    lat = 1;
    ok  = 1'b0;
    c   = 0;
    s   = 0;
    for (int i = 0; i < 60; i++) begin
      if (card_valid) begin
        ok = 1'b1;
        c  = int'(card);
        s  = int'(suit);
        break;
      end
      step();
      lat++;
    end
    if (ok) step();
  endtask

  task automatic wait_start(input int target, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (start_of(lfsr_m) == target) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(tag, int'(found), 1);
  endtask

  initial begin
    int   lat, c, s, vcount, uniq;
    logic ok;
    logic seen [52];
    int   rank_cnt [14];

    step();
    step();
    check("rst_card", int'(card), 0);
    check("rst_suit", int'(suit), 0);
    check("rst_valid", int'(card_valid), 0);
    check("rst_err", int'(draw_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_remaining", int'(remaining), 52);
    check("rst_low", int'(low_shoe), 0);
    reset = 1'b0;

    // First cycle after reset: lfsr=01 -> start idx 1 -> rank 2, suit 0.
    do_draw(1'b0, lat, c, s, ok);
    check("first_ok", int'(ok), 1);
    check("first_lat", lat, 2);
    check("first_card", c, 2);
    check("first_suit", s, 0);
    check("first_rem", int'(remaining), 51);

    // Start at the used slot 1: one skip, deal idx 2.
    wait_start(1, "coll_wait");
    do_draw(1'b0, lat, c, s, ok);
    check("coll_lat", lat, 3);
    check("coll_card", c, 3);
    check("coll_suit", s, 0);
    check("coll_rem", int'(remaining), 50);

    // Deal idx 51, then start at 51 again so the probe wraps to idx 0.
    wait_start(51, "wrap_wait1");
    do_draw(1'b0, lat, c, s, ok);
    check("k51_card", c, 13);
    check("k51_suit", s, 3);
    wait_start(51, "wrap_wait2");
    do_draw(1'b0, lat, c, s, ok);
    check("wrap_lat", lat, 3);
    check("wrap_card", c, 1);
    check("wrap_suit", s, 0);
    check("wrap_rem", int'(remaining), 48);

    // Draw requests while busy are ignored.
    draw = 1'b1;
    step();
    check("busy_search", int'(busy), 1);
    vcount = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 2) draw = 1'b0;
      if (card_valid) vcount++;
      step();
    end
    draw = 1'b0;
    check("busy_single_valid", vcount, 1);
    check("busy_rem", int'(remaining), 47);

    for (int i = 0; i < 15; i++) do_draw(1'b0, lat, c, s, ok);
    check("twenty_rem", int'(remaining), 32);
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    check("shuf_rem", int'(remaining), 52);
    check("shuf_low", int'(low_shoe), 0);
    check("shuf_busy", int'(busy), 0);

    for (int i = 0; i < 20; i++) do_draw(1'b0, lat, c, s, ok);
    check("pre_combo_rem", int'(remaining), 32);
    do_draw(1'b1, lat, c, s, ok);
    check("combo_ok", int'(ok), 1);
    check("combo_rem", int'(remaining), 31);

    // Full exhaust from a fresh shoe.
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    for (int i = 0; i < 52; i++) seen[i] = 1'b0;
    for (int r = 0; r < 14; r++) rank_cnt[r] = 0;
    uniq = 0;
    for (int i = 0; i < 52; i++) begin
      do_draw(1'b0, lat, c, s, ok);
      check("exh_ok", int'(ok), 1);
      if (ok && c >= 1 && c <= 13) begin
        if (!seen[s * 13 + c - 1]) uniq++;
        seen[s * 13 + c - 1] = 1'b1;
        rank_cnt[c]++;
      end
      if (i == 36) check("low_at_15", int'(low_shoe), 0);
      if (i == 37) check("low_at_14", int'(low_shoe), 1);
    end
    check("exh_distinct", uniq, 52);
    for (int r = 1; r <= 13; r++) check($sformatf("exh_rank%0d", r), rank_cnt[r], 4);
    check("exh_rem", int'(remaining), 0);

    // 53rd draw on an empty shoe.
    draw = 1'b1;
    step();
    draw = 1'b0;
    check("empty_err", int'(draw_err), 1);
    check("empty_valid", int'(card_valid), 0);
    check("empty_busy", int'(busy), 0);
    step();
    check("empty_err_pulse", int'(draw_err), 0);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (card_valid) vcount++;
      step();
    end
    check("empty_no_valid", vcount, 0);

    // Reset during SEARCH.
    shuffle = 1'b1;
    step();
    shuffle = 1'b0;
    draw = 1'b1;
    step();
    draw = 1'b0;
    check("midrst_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    check("midrst_valid", int'(card_valid), 0);
    check("midrst_busy_after", int'(busy), 0);
    check("midrst_rem", int'(remaining), 52);
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (card_valid) vcount++;
      step();
    end
    check("midrst_no_valid", vcount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
